// File: rtl/nco_pkg.sv
// Shared widths, phase constants and shadow-slot state for the NCO
// and the downstream CORDIC.
package nco_pkg;

   localparam int ACC_WIDTH  = 32;
   localparam int DATA_WIDTH = 20;

   localparam logic [DATA_WIDTH-1:0] PI_D2    = 20'h40000;
   localparam logic [DATA_WIDTH-1:0] PI       = 20'h80000;
   localparam logic [DATA_WIDTH-1:0] PI_M3_D2 = 20'hC0000;

   typedef enum logic {
      EMPTY,
      FULL
   } shadow_state_e;

endpackage

// File: rtl/ftw_shadow_reg.sv
// One-deep shadow slot for the tuning word: accepts over valid/ready,
// then signals when the pending word may be made active.
import nco_pkg::*;

module ftw_shadow_reg #(
   parameter int W = ACC_WIDTH
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] ftw_i,
   input  logic         ftw_valid_i,
   output logic         ftw_ready_o,
   input  logic         upd_mode_i,
   input  logic         en_i,
   input  logic         sync_clr_i,
   input  logic         carry_i,
   output logic         apply_o,
   output logic [W-1:0] ftw_pend_o
);

   shadow_state_e state_q, state_d;
   logic [W-1:0]  pend_q, pend_d;

   // In wrap mode a phase restart is also a safe point to retune
   assign apply_o = (state_q == FULL) &&
                    (!upd_mode_i || sync_clr_i || (en_i && carry_i));

   assign ftw_ready_o = (state_q == EMPTY) && !rst;
   assign ftw_pend_o  = pend_q;

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      unique case (state_q)
         EMPTY: begin
            if (ftw_valid_i) begin
               pend_d  = ftw_i;
               state_d = FULL;
            end
         end
         FULL: begin
            if (apply_o) state_d = EMPTY;
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
      end
   end

endmodule

// File: rtl/nco_phase_acc.sv
// Phase accumulator with shadowed tuning word; emits the registered,
// offset phase word consumed by the CORDIC.
import nco_pkg::*;

module nco_phase_acc #(
   parameter int ACC_WIDTH  = nco_pkg::ACC_WIDTH,
   parameter int DATA_WIDTH = nco_pkg::DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  sync_clr,
   input  logic                  upd_mode,
   input  logic [ACC_WIDTH-1:0]  ftw_in,
   input  logic                  ftw_valid,
   output logic                  ftw_ready,
   input  logic [DATA_WIDTH-1:0] pof_in,
   output logic [DATA_WIDTH-1:0] phase_out,
   output logic                  phase_valid,
   output logic                  wrap
);

   logic [ACC_WIDTH-1:0]  acc_q, acc_d;
   logic [ACC_WIDTH-1:0]  ftw_act_q, ftw_act_d;
   logic [ACC_WIDTH-1:0]  ftw_pend;
   logic [ACC_WIDTH:0]    sum;
   logic                  carry;
   logic                  apply;
   logic [DATA_WIDTH-1:0] phase_q, phase_d;
   logic                  valid_q, valid_d;
   logic                  wrap_q, wrap_d;

   ftw_shadow_reg #(
      .W (ACC_WIDTH)
   ) u_shadow (
      .clk         (clk),
      .rst         (rst),
      .ftw_i       (ftw_in),
      .ftw_valid_i (ftw_valid),
      .ftw_ready_o (ftw_ready),
      .upd_mode_i  (upd_mode),
      .en_i        (en),
      .sync_clr_i  (sync_clr),
      .carry_i     (carry),
      .apply_o     (apply),
      .ftw_pend_o  (ftw_pend)
   );

   assign sum   = {1'b0, acc_q} + {1'b0, ftw_act_q};
   assign carry = sum[ACC_WIDTH];

   always_comb begin
      acc_d = acc_q;
      if (sync_clr)  acc_d = '0;
      else if (en)   acc_d = sum[ACC_WIDTH-1:0];
   end

   // New word takes effect from the step after the apply edge
   assign ftw_act_d = apply ? ftw_pend : ftw_act_q;

   assign phase_d = acc_q[ACC_WIDTH-1 -: DATA_WIDTH] + pof_in;
   assign valid_d = en && !sync_clr;
   assign wrap_d  = en && !sync_clr && carry;

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q     <= '0;
         ftw_act_q <= '0;
         phase_q   <= '0;
         valid_q   <= 1'b0;
         wrap_q    <= 1'b0;
      end else begin
         acc_q     <= acc_d;
         ftw_act_q <= ftw_act_d;
         phase_q   <= phase_d;
         valid_q   <= valid_d;
         wrap_q    <= wrap_d;
      end
   end

   assign phase_out   = phase_q;
   assign phase_valid = valid_q;
   assign wrap        = wrap_q;

endmodule

// File: tb/tb_nco_phase_acc.sv
// Scoreboard bench for nco_phase_acc: directed vectors push expected
// phase/wrap pairs, a negedge monitor pops them on phase_valid.
module tb_nco_phase_acc;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        sync_clr;
   logic        upd_mode;
   logic [31:0] ftw_in;
   logic        ftw_valid;
   logic        ftw_ready;
   logic [19:0] pof_in;
   logic [19:0] phase_out;
   logic        phase_valid;
   logic        wrap;

   int checks = 0;
   int errors = 0;

   logic [20:0] sb_q[$];

   always #5 clk = ~clk;

   nco_phase_acc dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .sync_clr    (sync_clr),
      .upd_mode    (upd_mode),
      .ftw_in      (ftw_in),
      .ftw_valid   (ftw_valid),
      .ftw_ready   (ftw_ready),
      .pof_in      (pof_in),
      .phase_out   (phase_out),
      .phase_valid (phase_valid),
      .wrap        (wrap)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %h required %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [19:0] ph, input logic wr);
      sb_q.push_back({wr, ph});
   endtask

   // one enabled step with its expected sample
   task automatic step(input logic [19:0] ph, input logic wr);
      en = 1'b1;
      push(ph, wr);
      tick();
   endtask

   task automatic send_ftw(input logic [31:0] v);
      bit done = 0;
      ftw_in    = v;
      ftw_valid = 1'b1;
      for (int i = 0; i < 50 && !done; i++) begin
         if (ftw_ready) done = 1;
         tick();
      end
      ftw_valid = 1'b0;
      if (!done) begin
         errors++;
         checks++;
         $display("FAIL ftw_handshake_timeout actual 0 required 1");
      end
   endtask

   always @(negedge clk) begin
      logic [20:0] e;
      if (phase_valid) begin
         if (sb_q.size() == 0) begin
            chk("sb_unexpected_valid", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            chk("phase_out", {12'd0, phase_out}, {12'd0, e[19:0]});
            chk("wrap", {31'd0, wrap}, {31'd0, e[20]});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout actual running required finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      en        = 1'b0;
      sync_clr  = 1'b0;
      upd_mode  = 1'b0;
      ftw_in    = '0;
      ftw_valid = 1'b0;
      pof_in    = '0;
      repeat (3) tick();
      chk("rst_ftw_ready", {31'd0, ftw_ready}, 32'd0);
      chk("rst_phase_out", {12'd0, phase_out}, 32'd0);
      chk("rst_phase_valid", {31'd0, phase_valid}, 32'd0);
      chk("rst_wrap", {31'd0, wrap}, 32'd0);
      rst = 1'b0;
      #1;
      chk("ready_after_rst", {31'd0, ftw_ready}, 32'd1);

      // quarter-circle steps, immediate update
      send_ftw(32'h4000_0000);
      chk("ready_low_full", {31'd0, ftw_ready}, 32'd0);
      tick();
      chk("ready_after_apply", {31'd0, ftw_ready}, 32'd1);
      step(20'h00000, 0);
      step(20'h40000, 0);
      step(20'h80000, 0);
      step(20'hC0000, 1);
      step(20'h00000, 0);
      step(20'h40000, 0);
      step(20'h80000, 0);
      step(20'hC0000, 1);

      // same with quarter-circle offset
      pof_in = 20'h40000;
      step(20'h40000, 0);
      step(20'h80000, 0);
      step(20'hC0000, 0);
      step(20'h00000, 1);
      en     = 1'b0;
      pof_in = 20'h0;

      // fine step, then enable gap
      send_ftw(32'h0000_1000);
      tick();
      step(20'h00000, 0);
      step(20'h00001, 0);
      step(20'h00002, 0);
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("gap_valid", {31'd0, phase_valid}, 32'd0);
         chk("gap_phase", {12'd0, phase_out}, 32'h3);
      end
      step(20'h00003, 0);
      step(20'h00004, 0);
      step(20'h00005, 0);

      // sync_clr: first edge shows pre-clear acc, second shows pof
      en       = 1'b1;
      sync_clr = 1'b1;
      tick();
      chk("clr1_valid", {31'd0, phase_valid}, 32'd0);
      chk("clr1_phase", {12'd0, phase_out}, 32'h6);
      tick();
      chk("clr2_phase", {12'd0, phase_out}, 32'h0);
      sync_clr = 1'b0;
      en       = 1'b0;

      // wrap-synchronous retune
      send_ftw(32'h4000_0000);
      tick();
      upd_mode = 1'b1;
      step(20'h00000, 0);
      step(20'h40000, 0);
      ftw_in    = 32'h2000_0000;
      ftw_valid = 1'b1;
      chk("mode1_ready", {31'd0, ftw_ready}, 32'd1);
      step(20'h80000, 0);
      ftw_valid = 1'b0;
      chk("mode1_hold_ready", {31'd0, ftw_ready}, 32'd0);
      step(20'hC0000, 1);
      chk("mode1_ready_post", {31'd0, ftw_ready}, 32'd1);
      step(20'h00000, 0);
      step(20'h20000, 0);
      step(20'h40000, 0);
      step(20'h60000, 0);

      // second word held while slot is full
      ftw_in    = 32'h1000_0000;
      ftw_valid = 1'b1;
      step(20'h80000, 0);
      ftw_in = 32'h4000_0000;
      chk("full_ready0", {31'd0, ftw_ready}, 32'd0);
      step(20'hA0000, 0);
      chk("full_ready1", {31'd0, ftw_ready}, 32'd0);
      step(20'hC0000, 0);
      chk("full_ready2", {31'd0, ftw_ready}, 32'd0);
      step(20'hE0000, 1);
      chk("full_ready3", {31'd0, ftw_ready}, 32'd1);
      step(20'h00000, 0);
      ftw_valid = 1'b0;
      chk("second_taken", {31'd0, ftw_ready}, 32'd0);
      step(20'h10000, 0);
      sync_clr = 1'b1;
      tick();
      sync_clr = 1'b0;
      chk("clr_apply_phase", {12'd0, phase_out}, 32'h20000);
      chk("clr_apply_ready", {31'd0, ftw_ready}, 32'd1);
      step(20'h00000, 0);
      step(20'h40000, 0);

      // reset mid-run with a word pending
      ftw_in    = 32'h0800_0000;
      ftw_valid = 1'b1;
      step(20'h80000, 0);
      ftw_valid = 1'b0;
      en        = 1'b0;
      rst       = 1'b1;
      tick();
      tick();
      chk("mid_rst_valid", {31'd0, phase_valid}, 32'd0);
      chk("mid_rst_phase", {12'd0, phase_out}, 32'd0);
      chk("mid_rst_ready", {31'd0, ftw_ready}, 32'd0);
      rst      = 1'b0;
      upd_mode = 1'b0;
      pof_in   = 20'h12345;
      #1;
      chk("post_rst_ready", {31'd0, ftw_ready}, 32'd1);
      for (int i = 0; i < 4; i++) step(20'h12345, 0);
      en = 1'b0;
      repeat (3) tick();
      chk("sb_drained", sb_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
